// File: rtl/seq_div.sv
// rtl/seq_div.sv - multi-cycle restoring shift-subtract integer divider
//
// Divides a by b, one quotient bit per clock, for the DIV/DIVU execute path.
// A request is accepted on start while idle. busy stays high until the edge that
// raises the one-cycle done pulse. q and r hold their values until the next done.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request strobe, sampled only while idle
//   a, b     dividend / divisor, captured on an accepted start
//   isSigned 1 = two's-complement divide, 0 = unsigned
//   busy     high from the accept edge until the edge that raises done
//   done     one-cycle result-valid pulse
//   q, r     quotient / remainder
//
// Build option SEQ_DIV_ZERO_SHORTCUT_EN: when defined, a zero divisor skips the
// iterations and finishes on the edge after acceptance.

module seq_div #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             isSigned,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH:0]   rem_q, rem_d;       // partial remainder
   logic [WIDTH-1:0] dvd_q, dvd_d;       // dividend, shifts out as quotient shifts in
   logic [WIDTH-1:0] dsr_q, dsr_d;       // divisor magnitude
   logic             quo_neg_q, quo_neg_d;
   logic             rem_neg_q, rem_neg_d;
   logic             div0_q, div0_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;

   logic [WIDTH+1:0] shifted;
   logic             ge;
   logic             b_zero;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] mag_a, mag_b;

   assign b_zero  = (b == '0);
   assign a_neg   = isSigned & a[WIDTH-1];
   assign b_neg   = isSigned & b[WIDTH-1];
   assign mag_a   = a_neg ? -a : a;
   assign mag_b   = b_neg ? -b : b;
   assign shifted = {rem_q, dvd_q[WIDTH-1]};
   assign ge      = (shifted >= {2'b00, dsr_q});

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      rem_d     = rem_q;
      dvd_d     = dvd_q;
      dsr_d     = dsr_q;
      quo_neg_d = quo_neg_q;
      rem_neg_d = rem_neg_q;
      div0_d    = div0_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      q_d       = q_q;
      r_d       = r_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               // A zero divisor keeps the raw dividend and unsigned sense, so the
               // iterations leave the remainder equal to a.
               dvd_d     = b_zero ? a : mag_a;
               dsr_d     = mag_b;
               quo_neg_d = (a_neg ^ b_neg) & ~b_zero;
               rem_neg_d = a_neg & ~b_zero;
               div0_d    = b_zero;
               rem_d     = '0;
               count_d   = '0;
               busy_d    = 1'b1;
               state_d   = S_CALC;
`ifdef SEQ_DIV_ZERO_SHORTCUT_EN
               if (b_zero) begin
                  rem_d   = {1'b0, a};
                  state_d = S_FIX;
               end
`endif
            end
         end
         S_CALC: begin
            rem_d   = ge ? (shifted[WIDTH:0] - {1'b0, dsr_q}) : shifted[WIDTH:0];
            dvd_d   = {dvd_q[WIDTH-2:0], ge};
            count_d = count_q + 1'b1;
            if (count_q == LAST) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            if (div0_q) begin
               q_d = '1;
               r_d = rem_q[WIDTH-1:0];
            end else begin
               q_d = quo_neg_q ? -dvd_q : dvd_q;
               r_d = rem_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            count_d = '0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         rem_q     <= '0;
         dvd_q     <= '0;
         dsr_q     <= '0;
         quo_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         div0_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         q_q       <= '0;
         r_q       <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         rem_q     <= rem_d;
         dvd_q     <= dvd_d;
         dsr_q     <= dsr_d;
         quo_neg_q <= quo_neg_d;
         rem_neg_q <= rem_neg_d;
         div0_q    <= div0_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         q_q       <= q_d;
         r_q       <= r_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign q    = q_q;
   assign r    = r_q;

endmodule

// File: tb/tb_seq_div.sv
// tb/tb_seq_div.sv - self-checking bench for seq_div against an arithmetic model

module tb_seq_div;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic        isSigned;
   logic        busy;
   logic        done;
   logic [31:0] q;
   logic [31:0] r;

   int errors = 0;
   int checks = 0;

`ifdef SEQ_DIV_ZERO_SHORTCUT_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = 33;
`endif

   seq_div #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a        (a),
      .b        (b),
      .isSigned (isSigned),
      .busy     (busy),
      .done     (done),
      .q        (q),
      .r        (r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Division defined by plain integer arithmetic: truncation toward zero,
   // remainder follows the dividend, zero divisor gives all-ones and a.
   function automatic void ref_div(input logic [31:0] x, input logic [31:0] y, input logic s,
                                   output logic [31:0] eq, output logic [31:0] er);
      longint sx, sy;
      if (y == 32'd0) begin
         eq = 32'hFFFF_FFFF;
         er = x;
      end else if (s) begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
         eq = 32'(sx / sy);
         er = 32'(sx % sy);
      end else begin
         eq = x / y;
         er = x % y;
      end
   endfunction

   // Entered #1 after an edge with the divider idle. Returns #1 after the
   // edge that raised done (or after the wait bound expired).
   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic ts,
                         input int pulse_at, input bit drop_check);
      logic [31:0] eq, er;
      int lat, busy_cnt, exp_lat;
      ref_div(ta, tb_, ts, eq, er);
      exp_lat  = (tb_ == 32'd0) ? ZLAT : 33;
      a        = ta;
      b        = tb_;
      isSigned = ts;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      a        = $urandom;
      b        = $urandom;
      isSigned = 1'($urandom_range(0, 1));
      check("busy_after_accept", {31'd0, busy}, 32'd1);
      busy_cnt = 1;
      lat      = 0;
      while (lat < 100) begin
         if (pulse_at > 0 && lat == pulse_at - 1) begin
            start = 1'b1;
            a     = $urandom;
            b     = $urandom_range(1, 50);
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         lat++;
         if (done) break;
         if (busy) busy_cnt++;
      end
      check("done_latency", lat, exp_lat);
      check("busy_cycles", busy_cnt, exp_lat);
      check("busy_low_at_done", {31'd0, busy}, 32'd0);
      check("quotient", q, eq);
      check("remainder", r, er);
      if (drop_check) begin
         @(posedge clk);
         #1;
         check("done_one_cycle", {31'd0, done}, 32'd0);
         check("q_held", q, eq);
         check("r_held", r, er);
      end
   endtask

   task automatic no_done_window(input string tag, input int cycles);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      check(tag, seen, 0);
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      a        = '0;
      b        = '0;
      isSigned = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_q", q, 32'd0);
      check("reset_r", r, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_op(32'd100, 32'd7, 1'b0, 0, 1'b1);
      run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 1'b1);
      run_op(32'hFFFF_FFFF, 32'd2, 1'b0, 0, 1'b1);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b1);
      run_op(32'h1234_5678, 32'd0, 1'b0, 0, 1'b1);
      run_op(32'h1234_5678, 32'd0, 1'b1, 0, 1'b1);
      run_op(32'hFFFF_FFF9, 32'd0, 1'b1, 0, 1'b1);

      // start while busy is ignored and leaves no queued result
      run_op(32'd1000, 32'd33, 1'b0, 5, 1'b0);
      no_done_window("no_extra_done_after_ignored_start", 40);

      // reset mid-operation aborts with outputs cleared
      a        = 32'd555;
      b        = 32'd5;
      isSigned = 1'b0;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_q", q, 32'd0);
      check("midrst_r", r, 32'd0);
      #3;
      rst_n = 1'b1;
      no_done_window("no_done_after_reset", 40);

      // start raised in the done cycle is accepted
      run_op(32'd50000, 32'd123, 1'b0, 0, 1'b0);
      run_op(32'hFFFF_0000, 32'd77, 1'b1, 0, 1'b1);

      // randomized operands, some back-to-back
      for (int i = 0; i < 12; i++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = $urandom_range(1, 15);
            1:       rb = (($urandom_range(0, 5) == 0) ? 32'd0 : $urandom);
            2:       rb = -32'($urandom_range(1, 1000));
            default: rb = $urandom >> $urandom_range(0, 31);
         endcase
         run_op(ra, rb, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
